// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types: word, packet length, rx descriptor, rx cache defaults.
// Pure declarations; no logic, no latency, no flow control.
package chiplet_types_pkg;

    localparam int WORD_WIDTH       = 32;
    localparam int PKT_LENGTH_WIDTH = 16;

    localparam int RX_CACHE_BYTES   = 1024;
    localparam int RX_MAX_PKT_WORDS = 128;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t                       start_addr;
        logic [PKT_LENGTH_WIDTH-1:0] length;
    } rx_desc_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_POP,
        RX_FETCH,
        RX_WAIT,
        RX_SEND
    } rx_drain_state_t;

    // Word-aligned byte address folded into a power-of-two cache.
    function automatic word_t rx_cache_wrap(input word_t addr, input int cache_bytes);
        return addr & word_t'(cache_bytes - 4);
    endfunction

endpackage

// File: rtl/rx_drain_fsm.sv
// Drains rx-cache packets described by descriptors to a host word handshake; optional RX_DRAIN_STATS_EN adds a drained-packet counter.
// Latency: 3 cycles from descriptor pop to first rd_valid; one word per 3 cycles at full rate.
// Backpressure: rd_ready=0 holds SEND with rd_data/rd_last stable; no cache reads while stalled.
module rx_drain_fsm
    import chiplet_types_pkg::*;
#(
    parameter int CACHE_BYTES   = RX_CACHE_BYTES,
    parameter int MAX_PKT_WORDS = RX_MAX_PKT_WORDS
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        desc_empty,
    input  rx_desc_t                    desc_rdata,
    output logic                        desc_pop,
    output logic                        cache_ren,
    output word_t                       cache_raddr,
    input  word_t                       cache_rdata,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output word_t                       rd_data,
    output logic                        rd_last,
    input  logic                        commit_valid,
    input  logic [PKT_LENGTH_WIDTH-1:0] commit_len,
    output logic                        overflow,
    output logic [15:0]                 pkt_count
);

    localparam int CACHE_WORDS = CACHE_BYTES / 4;
    localparam int OCC_W       = $clog2(CACHE_WORDS) + 1;
    localparam int SUM_W       = ((OCC_W > PKT_LENGTH_WIDTH) ? OCC_W : PKT_LENGTH_WIDTH) + 1;
    localparam logic [OCC_W-1:0] OCC_MAX    = '1;
    localparam logic [OCC_W-1:0] OCC_THRESH = OCC_W'(CACHE_WORDS - MAX_PKT_WORDS);

    rx_drain_state_t             r_state;
    rx_drain_state_t             w_next;
    word_t                       r_addr;
    logic [PKT_LENGTH_WIDTH-1:0] r_rem;
    word_t                       r_rd_data;
    logic [OCC_W-1:0]            r_occ;
    logic [OCC_W-1:0]            w_occ_next;
    logic [SUM_W-1:0]            w_occ_sum;
    logic                        w_hs;
    logic                        w_rem_one;

    assign w_rem_one   = (r_rem == PKT_LENGTH_WIDTH'(1));
    assign rd_valid    = (r_state == RX_SEND);
    assign rd_last     = rd_valid && w_rem_one;
    assign rd_data     = r_rd_data;
    assign cache_raddr = cache_ren ? r_addr : '0;
    assign overflow    = (r_occ > OCC_THRESH);

    always_comb begin
        w_next    = r_state;
        desc_pop  = 1'b0;
        cache_ren = 1'b0;
        w_hs      = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!desc_empty) w_next = RX_POP;
            end
            RX_POP: begin
                if (desc_empty) begin
                    w_next = RX_IDLE;
                end else begin
                    desc_pop = 1'b1;
                    // Zero-length descriptors are consumed without touching the cache.
                    w_next   = (desc_rdata.length == '0) ? RX_IDLE : RX_FETCH;
                end
            end
            RX_FETCH: begin
                cache_ren = 1'b1;
                w_next    = RX_WAIT;
            end
            RX_WAIT: begin
                w_next = RX_SEND;
            end
            RX_SEND: begin
                if (rd_ready) begin
                    w_hs   = 1'b1;
                    w_next = w_rem_one ? RX_IDLE : RX_FETCH;
                end
            end
            default: w_next = RX_IDLE;
        endcase
    end

    // Commit and drain in the same cycle net out; the drain never takes occupancy below zero.
    always_comb begin
        w_occ_sum = SUM_W'(r_occ) + (commit_valid ? SUM_W'(commit_len) : SUM_W'(0));
        if (w_hs && (w_occ_sum != '0)) w_occ_sum = w_occ_sum - SUM_W'(1);
        w_occ_next = (w_occ_sum > SUM_W'(OCC_MAX)) ? OCC_MAX : w_occ_sum[OCC_W-1:0];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= RX_IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_rd_data <= '0;
            r_occ     <= '0;
        end else begin
            r_state <= w_next;
            r_occ   <= w_occ_next;
            if (desc_pop) begin
                r_addr <= rx_cache_wrap(desc_rdata.start_addr, CACHE_BYTES);
                r_rem  <= desc_rdata.length;
            end
            if (r_state == RX_WAIT) r_rd_data <= cache_rdata;
            if (w_hs) begin
                r_rem  <= r_rem - PKT_LENGTH_WIDTH'(1);
                r_addr <= rx_cache_wrap(r_addr + word_t'(4), CACHE_BYTES);
            end
        end
    end

`ifdef RX_DRAIN_STATS_EN
    logic [15:0] r_pkt_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pkt_count <= '0;
        end else if (w_hs && rd_last) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    assign pkt_count = r_pkt_count;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_rx_drain_fsm.sv
// Scoreboard bench for rx_drain_fsm: descriptor FIFO and cache models, expected addresses/beats queued at push time.
module tb_rx_drain_fsm;
    import chiplet_types_pkg::*;

    localparam int CB = 1024;

    typedef struct packed {
        word_t dat;
        logic  last;
    } beat_t;

    logic                        clk;
    logic                        n_rst;
    logic                        desc_empty;
    rx_desc_t                    desc_rdata;
    logic                        desc_pop;
    logic                        cache_ren;
    word_t                       cache_raddr;
    word_t                       cache_rdata;
    logic                        rd_valid;
    logic                        rd_ready;
    word_t                       rd_data;
    logic                        rd_last;
    logic                        commit_valid;
    logic [PKT_LENGTH_WIDTH-1:0] commit_len;
    logic                        overflow;
    logic [15:0]                 pkt_count;

    rx_drain_fsm #(.CACHE_BYTES(CB), .MAX_PKT_WORDS(128)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .desc_empty   (desc_empty),
        .desc_rdata   (desc_rdata),
        .desc_pop     (desc_pop),
        .cache_ren    (cache_ren),
        .cache_raddr  (cache_raddr),
        .cache_rdata  (cache_rdata),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .commit_valid (commit_valid),
        .commit_len   (commit_len),
        .overflow     (overflow),
        .pkt_count    (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       n_err;
    int       n_chk;
    int       cyc;
    int       n_pops;
    int       n_beats;
    int       last_hs_cyc;
    int       hs_gap;
    logic     s_desc_pop;
    logic     s_ren;
    logic     s_vld;
    word_t    s_raddr;
    rx_desc_t dq[$];
    word_t    q_addr[$];
    beat_t    q_beat[$];

    task automatic check_eq(input string tag, input word_t act, input word_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic word_t cache_word(input word_t a);
        return 32'hD00D_0000 ^ (a << 10) ^ a;
    endfunction

    task automatic push_desc(input word_t addr, input int len);
        rx_desc_t d;
        word_t    a;
        beat_t    b;
        d.start_addr = addr;
        d.length     = PKT_LENGTH_WIDTH'(len);
        dq.push_back(d);
        a = addr & word_t'(CB - 4);
        for (int i = 0; i < len; i++) begin
            q_addr.push_back(a);
            b.dat  = cache_word(a);
            b.last = (i == len - 1);
            q_beat.push_back(b);
            a = (a + 32'd4) & word_t'(CB - 4);
        end
        desc_empty = 1'b0;
        desc_rdata = dq[0];
    endtask

    // One clock: observe/score at negedge, update FIFO and cache models just after posedge.
    task automatic tick();
        beat_t b;
        word_t a;
        @(negedge clk);
        cyc++;
        s_desc_pop = desc_pop;
        s_ren      = cache_ren;
        s_raddr    = cache_raddr;
        s_vld      = rd_valid;
        if (desc_pop) begin
            n_pops++;
            check_eq("pop_nonempty", 32'(desc_empty), 0);
        end
        if (cache_ren) begin
            check_eq("ren_expected", 32'(q_addr.size() > 0), 1);
            if (q_addr.size() > 0) begin
                a = q_addr.pop_front();
                check_eq("raddr", cache_raddr, a);
            end
        end
        if (rd_valid && rd_ready) begin
            check_eq("beat_expected", 32'(q_beat.size() > 0), 1);
            if (q_beat.size() > 0) begin
                b = q_beat.pop_front();
                check_eq("rd_data", rd_data, b.dat);
                check_eq("rd_last", 32'(rd_last), 32'(b.last));
            end
            n_beats++;
            if (last_hs_cyc > 0) hs_gap = cyc - last_hs_cyc;
            last_hs_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (s_desc_pop && dq.size() > 0) void'(dq.pop_front());
        desc_empty = (dq.size() == 0);
        desc_rdata = (dq.size() > 0) ? dq[0] : '0;
        if (s_ren) cache_rdata = cache_word(s_raddr);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((dq.size() > 0 || q_addr.size() > 0 || q_beat.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(dq.size() + q_addr.size() + q_beat.size()), 0);
        repeat (3) tick();
    endtask

    task automatic wait_vld(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_vld && n < budget);
        check_eq(tag, 32'(s_vld), 1);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check_eq({tag, "_pop"},   32'(desc_pop), 0);
        check_eq({tag, "_ren"},   32'(cache_ren), 0);
        check_eq({tag, "_raddr"}, cache_raddr, 0);
        check_eq({tag, "_vld"},   32'(rd_valid), 0);
        check_eq({tag, "_data"},  rd_data, 0);
        check_eq({tag, "_last"},  32'(rd_last), 0);
        check_eq({tag, "_ovf"},   32'(overflow), 0);
        check_eq({tag, "_cnt"},   32'(pkt_count), 0);
        check_eq({tag, "_state"}, 32'(dut.r_state), 32'(RX_IDLE));
        check_eq({tag, "_occ"},   32'(dut.r_occ), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pops0;
        int beats0;
        int lat;
        n_err = 0; n_chk = 0; cyc = 0; n_pops = 0; n_beats = 0;
        last_hs_cyc = 0; hs_gap = 0;
        s_desc_pop = 1'b0; s_ren = 1'b0; s_vld = 1'b0; s_raddr = '0;
        n_rst = 1'b0; desc_empty = 1'b1; desc_rdata = '0; cache_rdata = '0;
        rd_ready = 1'b1; commit_valid = 1'b0; commit_len = '0;

        repeat (2) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        n_rst = 1'b1;
        repeat (2) tick();

        // Three-word packet: latency from pop, throughput, one pop.
        pops0 = n_pops;
        push_desc(32'h010, 3);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_desc_pop && n < 20);
        check_eq("pop_seen", 32'(s_desc_pop), 1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!s_vld && lat < 20);
        check_eq("latency", 32'(lat), 3);
        wait_drain("drain_3w", 60);
        check_eq("gap_3w", 32'(hs_gap), 3);
        check_eq("pops_3w", 32'(n_pops - pops0), 1);
        check_eq("occ_sat0", 32'(dut.r_occ), 0);

        // Address wrap at the top of the cache.
        push_desc(word_t'(CB - 4), 2);
        wait_drain("drain_wrap", 60);

        // Zero-length descriptor is discarded, next packet delivered.
        pops0  = n_pops;
        beats0 = n_beats;
        push_desc(32'h000, 0);
        push_desc(32'h020, 1);
        wait_drain("drain_zero", 60);
        check_eq("pops_zero", 32'(n_pops - pops0), 2);
        check_eq("beats_zero", 32'(n_beats - beats0), 1);

        // Host stall in SEND for five cycles.
        rd_ready = 1'b0;
        push_desc(32'h040, 2);
        wait_vld("stall_vld0", 20);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_vld",  32'(s_vld), 1);
            check_eq("stall_ren",  32'(s_ren), 0);
            check_eq("stall_data", rd_data, q_beat[0].dat);
            check_eq("stall_last", 32'(rd_last), 32'(q_beat[0].last));
        end
        rd_ready = 1'b1;
        wait_drain("drain_stall", 60);

        // Occupancy thresholds.
        commit_valid = 1'b1;
        commit_len   = PKT_LENGTH_WIDTH'(32);
        repeat (4) tick();
        commit_valid = 1'b0;
        tick();
        check_eq("occ_128", 32'(dut.r_occ), 128);
        check_eq("ovf_128", 32'(overflow), 0);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        tick();
        check_eq("occ_160", 32'(dut.r_occ), 160);
        check_eq("ovf_160", 32'(overflow), 1);

        // Commit of one word coinciding with a handshake.
        rd_ready = 1'b0;
        push_desc(32'h080, 1);
        wait_vld("both_vld", 20);
        rd_ready     = 1'b1;
        commit_valid = 1'b1;
        commit_len   = PKT_LENGTH_WIDTH'(1);
        tick();
        commit_valid = 1'b0;
        tick();
        check_eq("occ_both", 32'(dut.r_occ), 160);
        wait_drain("drain_both", 60);

        // Reset while word 2 of 3 is being offered.
        rd_ready = 1'b0;
        push_desc(32'h100, 3);
        wait_vld("mid_w1", 20);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        wait_vld("mid_w2", 20);
        n_rst = 1'b0;
        #1;
        check_quiet_outputs("midrst");
        q_addr.delete();
        q_beat.delete();
        repeat (2) tick();
        n_rst    = 1'b1;
        rd_ready = 1'b1;
        repeat (6) tick();
        check_eq("post_rst_idle", 32'(s_vld), 0);

        // Two full packets after reset, the second wrapping.
        push_desc(32'h200, 2);
        push_desc(32'h3F8, 3);
        wait_drain("drain_two", 80);
`ifdef RX_DRAIN_STATS_EN
        check_eq("pkt_count", 32'(pkt_count), 2);
`else
        check_eq("pkt_count", 32'(pkt_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
